// File: rtl/pcie_tx_arb_pkg.sv
// pcie_tx_arb_pkg: arbiter state type and round-robin requester pick shared by the PCIe TX arbiter.
package pcie_tx_arb_pkg;
    typedef enum logic {IDLE, XFER} t_arb_state;
    localparam int MAX_REQ = 16;
    // First set bit of eligible found by searching from ptr+1 upward, modulo n; returns ptr if none.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] eligible, input logic [3:0] ptr, input int n);
        rr_pick = ptr;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n && eligible[4'((int'(ptr) + i) % n)]) rr_pick = 4'((int'(ptr) + i) % n);
        end
    endfunction
endpackage

// File: rtl/pcie_tx_skid_buf.sv
// pcie_tx_skid_buf: 2-entry AXI-S register slice; outputs and in_ready_o are fully registered.
module pcie_tx_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic         take;
    assign take        = out_ready_i | ~out_valid_q;
    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    // The skid entry only fills when the output register is stalled, so it always drains first.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (take) begin
            out_valid_d  = skid_valid_q | in_valid_i;
            out_data_d   = skid_valid_q ? skid_data_q : in_data_i;
            skid_valid_d = 1'b0;
        end else if (in_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/pcie_tx_pkt_arb.sv
// pcie_tx_pkt_arb: packet-locked round-robin arbiter merging NUM_REQ TX TLP streams into one AXI-S stream.
module pcie_tx_pkt_arb
    import pcie_tx_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 512,
    parameter int USER_W     = 10,
    parameter int BURST_PKTS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           in_tvalid,
    output logic [NUM_REQ-1:0]           in_tready,
    input  logic [NUM_REQ*DATA_W-1:0]    in_tdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]  in_tkeep,
    input  logic [NUM_REQ-1:0]           in_tlast,
    input  logic [NUM_REQ*USER_W-1:0]    in_tuser,
    input  logic [NUM_REQ-1:0]           req_mask,
    output logic                         out_tvalid,
    input  logic                         out_tready,
    output logic [DATA_W-1:0]            out_tdata,
    output logic [DATA_W/8-1:0]          out_tkeep,
    output logic                         out_tlast,
    output logic [USER_W-1:0]            out_tuser,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int KW = DATA_W / 8;
    localparam int W  = DATA_W + KW + USER_W + 1;
    t_arb_state          state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [3:0]          pkt_cnt_q, pkt_cnt_d;
    logic [NUM_REQ-1:0]  eligible;
    logic                skid_valid, skid_ready, beat;
    logic [W-1:0]        skid_in, skid_out;
    assign eligible   = in_tvalid & ~req_mask;
    assign skid_valid = (state_q == XFER) & in_tvalid[grant_q];
    assign beat       = skid_valid & skid_ready;
    assign in_tready  = (state_q == XFER) ? (NUM_REQ'(skid_ready) << grant_q) : '0;
    assign skid_in    = {in_tlast[grant_q], in_tuser[grant_q*USER_W +: USER_W],
                         in_tkeep[grant_q*KW +: KW], in_tdata[grant_q*DATA_W +: DATA_W]};
    assign {out_tlast, out_tuser, out_tkeep, out_tdata} = skid_out;
    assign grant_idx  = grant_q;
    assign busy       = (state_q == XFER);
    // A masked requester still finishes its current TLP; the mask only blocks the next one.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == IDLE) begin
            if (|eligible) begin
                grant_d   = GW'(rr_pick(MAX_REQ'(eligible), 4'(rr_ptr_q), NUM_REQ));
                rr_ptr_d  = grant_d;
                pkt_cnt_d = '0;
                state_d   = XFER;
            end
        end else if (beat && in_tlast[grant_q]) begin
            pkt_cnt_d = pkt_cnt_q + 4'd1;
            state_d   = ({1'b0, pkt_cnt_q} + 5'd1 < 5'(BURST_PKTS) && !req_mask[grant_q]) ? XFER : IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= GW'(NUM_REQ - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
    pcie_tx_skid_buf #(.W(W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (skid_valid),
        .in_ready_o  (skid_ready),
        .in_data_i   (skid_in),
        .out_valid_o (out_tvalid),
        .out_ready_i (out_tready),
        .out_data_o  (skid_out)
    );
endmodule

// File: tb/tb_pcie_tx_pkt_arb.sv
// tb_pcie_tx_pkt_arb: directed bench for the TX arbiter; instance 0 has BURST_PKTS=1, instance 1 has BURST_PKTS=2.
module tb_pcie_tx_pkt_arb;
    typedef struct packed {logic last; logic [9:0] user; logic [7:0] keep; logic [63:0] data;} beat_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0]   in_tvalid [2], in_tready [2], in_tlast [2], req_mask [2];
    logic [255:0] in_tdata [2];
    logic [31:0]  in_tkeep [2];
    logic [39:0]  in_tuser [2];
    logic         out_tvalid [2], out_tready [2], out_tlast [2], busy [2];
    logic [63:0]  out_tdata [2];
    logic [7:0]   out_tkeep [2];
    logic [9:0]   out_tuser [2];
    logic [1:0]   grant_idx [2];
    beat_t        mem [2][4][16];
    int           hd [2][4], tl [2][4];
    logic         en [2][4];
    beat_t        lg [2][32];
    int           lcyc [2][32];
    logic [1:0]   lgnt [2][32];
    int           lc [2];
    logic         stl [2];
    beat_t        held [2];
    logic [3:0]   fire [2];
    int           cyc, total, bad;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pcie_tx_pkt_arb #(.NUM_REQ(4), .DATA_W(64), .USER_W(10), .BURST_PKTS(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .in_tvalid(in_tvalid[g]), .in_tready(in_tready[g]), .in_tdata(in_tdata[g]),
            .in_tkeep(in_tkeep[g]), .in_tlast(in_tlast[g]), .in_tuser(in_tuser[g]),
            .req_mask(req_mask[g]),
            .out_tvalid(out_tvalid[g]), .out_tready(out_tready[g]), .out_tdata(out_tdata[g]),
            .out_tkeep(out_tkeep[g]), .out_tlast(out_tlast[g]), .out_tuser(out_tuser[g]),
            .grant_idx(grant_idx[g]), .busy(busy[g])
        );
    end
    function automatic beat_t mk(input int r, input int p, input int b, input int nb);
        beat_t t;
        t.data = 64'hC0DE_0000_0000_0000 | (64'(r) << 32) | (64'(p) << 16) | 64'(b);
        t.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
        t.user = 10'(r * 64 + p * 8 + b);
        t.last = (b == nb - 1);
        return t;
    endfunction
    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic chkb(input string tag, input beat_t obs, input beat_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic drive();
        beat_t b;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) begin
                b = (hd[d][r] < 16) ? mem[d][r][hd[d][r]] : '0;
                in_tvalid[d][r] = en[d][r] && (hd[d][r] < tl[d][r]);
                in_tdata[d][r*64 +: 64] = b.data;
                in_tkeep[d][r*8 +: 8] = b.keep;
                in_tuser[d][r*10 +: 10] = b.user;
                in_tlast[d][r] = b.last;
            end
        end
    endtask
    task automatic clear();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) begin
                hd[d][r] = 0;
                tl[d][r] = 0;
                en[d][r] = 1'b0;
            end
        end
    endtask
    task automatic clear_log(input int d);
        lc[d] = 0;
        for (int k = 0; k < 32; k++) lg[d][k] = '0;
    endtask
    task automatic load(input int d, input int r, input int p, input int nb);
        for (int b = 0; b < nb; b++) begin
            mem[d][r][tl[d][r]] = mk(r, p, b, nb);
            tl[d][r]++;
        end
    endtask
    // Sample handshakes mid-cycle, then pop accepted beats after the edge and re-drive.
    task automatic step();
        beat_t cur;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur = {out_tlast[d], out_tuser[d], out_tkeep[d], out_tdata[d]};
            fire[d] = in_tvalid[d] & in_tready[d];
            if (stl[d]) begin
                chki("stall_valid", int'(out_tvalid[d]), 1);
                chkb("stall_hold", cur, held[d]);
            end
            stl[d] = out_tvalid[d] & ~out_tready[d];
            held[d] = cur;
            if (out_tvalid[d] && out_tready[d] && lc[d] < 32) begin
                lg[d][lc[d]] = cur;
                lcyc[d][lc[d]] = cyc;
                lgnt[d][lc[d]] = grant_idx[d];
                lc[d]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 4; r++)
                if (fire[d][r]) hd[d][r]++;
        drive();
    endtask
    task automatic run(input int d, input int n, input int budget);
        for (int i = 0; i < budget && lc[d] < n; i++) step();
    endtask
    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            out_tready[d] = 1'b1;
            req_mask[d] = 4'h0;
            stl[d] = 1'b0;
            clear_log(d);
        end
        clear();
        drive();
        @(posedge clk);
        #1;
        chki("rst_tvalid", int'(out_tvalid[0]), 0);
        chki("rst_busy", int'(busy[0]), 0);
        chki("rst_tready", int'(in_tready[0]), 0);
        chki("rst_grant", int'(grant_idx[0]), 0);
        chki("rst_tvalid_b2", int'(out_tvalid[1]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Burst of 2 on instance 1: r1 twice back-to-back, then r2 (masked while granted), then r1.
        load(1, 1, 0, 1);
        load(1, 1, 1, 1);
        load(1, 1, 2, 1);
        load(1, 2, 0, 1);
        en[1][1] = 1'b1;
        en[1][2] = 1'b1;
        drive();
        for (int i = 0; i < 60 && lc[1] < 4; i++) begin
            step();
            if (busy[1] && grant_idx[1] == 2'd2) req_mask[1][2] = 1'b1;
        end
        chki("t2_count", lc[1], 4);
        chkb("t2_beat0", lg[1][0], mk(1, 0, 0, 1));
        chkb("t2_beat1", lg[1][1], mk(1, 1, 0, 1));
        chkb("t2_beat2", lg[1][2], mk(2, 0, 0, 1));
        chkb("t2_beat3", lg[1][3], mk(1, 2, 0, 1));
        chki("t2_gap1", lcyc[1][1] - lcyc[1][0], 1);
        chki("t2_gap2", lcyc[1][2] - lcyc[1][1], 2);
        chki("t2_gap3", lcyc[1][3] - lcyc[1][2], 2);
        repeat (2) step();
        chki("t2_hold_busy", int'(busy[1]), 1);
        chki("t2_hold_grant", int'(grant_idx[1]), 1);
        // Four requesters, one 3-beat TLP each.
        clear();
        clear_log(0);
        for (int r = 0; r < 4; r++) begin
            load(0, r, 0, 3);
            en[0][r] = 1'b1;
        end
        drive();
        run(0, 12, 100);
        chki("t1_count", lc[0], 12);
        for (int k = 0; k < 12; k++) begin
            chkb("t1_beat", lg[0][k], mk(k / 3, 0, k % 3, 3));
            if (k % 3 == 0) chki("t1_grant", int'(lgnt[0][k]), k / 3);
            if (k > 0) chki("t1_gap", lcyc[0][k] - lcyc[0][k-1], (k % 3 == 0) ? 2 : 1);
        end
        // Backpressure toggling in the middle of a 4-beat TLP.
        clear();
        clear_log(0);
        load(0, 0, 0, 4);
        en[0][0] = 1'b1;
        drive();
        run(0, 1, 20);
        for (int i = 0; i < 8; i++) begin
            out_tready[0] = (i % 2 == 0);
            step();
        end
        out_tready[0] = 1'b1;
        run(0, 4, 30);
        repeat (4) step();
        chki("t3_count", lc[0], 4);
        for (int k = 0; k < 4; k++) chkb("t3_beat", lg[0][k], mk(0, 0, k, 4));
        // Mask r0 during beat 2; its TLP still completes, then r1 wins and r0 stays out.
        clear();
        clear_log(0);
        load(0, 0, 0, 4);
        load(0, 0, 1, 1);
        en[0][0] = 1'b1;
        drive();
        for (int i = 0; i < 20 && hd[0][0] < 1; i++) step();
        req_mask[0][0] = 1'b1;
        load(0, 1, 0, 1);
        en[0][1] = 1'b1;
        drive();
        run(0, 5, 40);
        repeat (6) step();
        chki("t4_count", lc[0], 5);
        for (int k = 0; k < 4; k++) chkb("t4_beat", lg[0][k], mk(0, 0, k, 4));
        chkb("t4_r1", lg[0][4], mk(1, 0, 0, 1));
        chki("t4_r0_taken", hd[0][0], 4);
        chki("t4_grant", int'(grant_idx[0]), 1);
        chki("t4_busy", int'(busy[0]), 0);
        // Reset pulse during beat 3 of a 5-beat TLP.
        clear();
        req_mask[0] = 4'h0;
        clear_log(0);
        load(0, 0, 0, 5);
        en[0][0] = 1'b1;
        drive();
        for (int i = 0; i < 20 && hd[0][0] < 2; i++) step();
        chki("t5_pre_valid", int'(out_tvalid[0]), 1);
        rst = 1'b1;
        #1;
        chki("t5_rst_tvalid", int'(out_tvalid[0]), 0);
        chki("t5_rst_busy", int'(busy[0]), 0);
        chki("t5_rst_tready", int'(in_tready[0]), 0);
        chki("t5_rst_grant", int'(grant_idx[0]), 0);
        clear();
        stl[0] = 1'b0;
        stl[1] = 1'b0;
        load(0, 1, 0, 1);
        load(0, 2, 0, 1);
        en[0][1] = 1'b1;
        en[0][2] = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log(0);
        run(0, 2, 20);
        chki("t5_count", lc[0], 2);
        chkb("t5_first", lg[0][0], mk(1, 0, 0, 1));
        chkb("t5_second", lg[0][1], mk(2, 0, 0, 1));
        chki("t5_first_grant", int'(lgnt[0][0]), 1);
        // Lone requester 3 with ten single-beat TLPs.
        clear();
        clear_log(0);
        for (int p = 0; p < 10; p++) load(0, 3, p, 1);
        en[0][3] = 1'b1;
        drive();
        run(0, 10, 60);
        chki("t6_count", lc[0], 10);
        for (int k = 0; k < 10; k++) begin
            chkb("t6_beat", lg[0][k], mk(3, k, 0, 1));
            chki("t6_grant", int'(lgnt[0][k]), 3);
            if (k > 0) chki("t6_gap", lcyc[0][k] - lcyc[0][k-1], 2);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
